// File: rtl/dcache_data_bank_array.sv
// Banked data array: NUM_WAYS ways x NUM_WORDS sets, zero-swept after reset/flush, byte-masked writes, write-first reads.
// Define DCACHE_DATA_BANK_OUTREG_EN to register the merged read data (read latency 2 instead of 1).
module dcache_data_bank_array #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned NUM_WAYS   = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  output logic                                          init_done_o,
  input  logic                                          rd_req_i,
  input  logic [$clog2(NUM_WORDS)-1:0]                  rd_addr_i,
  output logic                                          rd_gnt_o,
  output logic                                          rd_valid_o,
  output logic [NUM_WAYS*DATA_WIDTH-1:0]                rd_data_o,
  input  logic                                          wr_req_i,
  input  logic [(NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1)-1:0] wr_way_i,
  input  logic [$clog2(NUM_WORDS)-1:0]                  wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0]                       wr_be_i,
  input  logic [DATA_WIDTH-1:0]                         wr_data_i,
  output logic                                          wr_gnt_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned LW = NUM_WAYS * DATA_WIDTH;

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic            rd_gnt, wr_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rd_gnt      = 1'b0;
    wr_gnt      = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      INIT: begin
        // A flush arriving here is ignored: the sweep simply carries on.
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(NUM_WORDS - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN: begin
        init_done_o = 1'b1;
        if (flush_i) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end else begin
          rd_gnt = rd_req_i;
          wr_gnt = wr_req_i;
        end
      end
    endcase
  end

  assign rd_gnt_o = rd_gnt;
  assign wr_gnt_o = wr_gnt;

  // Same-index write captured alongside the read so it can be merged over the old array data.
  logic              byp_hit_q;
  logic [WW-1:0]     byp_way_q;
  logic [BW-1:0]     byp_be_q;
  logic [DATA_WIDTH-1:0] byp_dat_q;

  always_ff @(posedge clk_i) begin
    if (rd_gnt) begin
      byp_hit_q <= wr_gnt && (wr_addr_i == rd_addr_i);
      byp_way_q <= wr_way_i;
      byp_be_q  <= wr_be_i;
      byp_dat_q <= wr_data_i;
    end
  end

  logic [LW-1:0] merged;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] raw_q;
    logic [DATA_WIDTH-1:0] way_merged;
    logic                  way_wr;

    assign way_wr = wr_gnt && (wr_way_i == WW'(w));

    always_ff @(posedge clk_i) begin
      if (state_q == INIT) begin
        mem_q[init_cnt_q] <= '0;
      end else if (way_wr) begin
        for (int b = 0; b < BW; b++) begin
          if (wr_be_i[b]) mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
      if (rd_gnt) raw_q <= mem_q[rd_addr_i];
    end

    always_comb begin
      way_merged = raw_q;
      if (byp_hit_q && (byp_way_q == WW'(w))) begin
        for (int b = 0; b < BW; b++) begin
          if (byp_be_q[b]) way_merged[b*8 +: 8] = byp_dat_q[b*8 +: 8];
        end
      end
    end

    assign merged[w*DATA_WIDTH +: DATA_WIDTH] = way_merged;
  end

  logic          rd_vld_q;
  logic [LW-1:0] merged_masked;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_vld_q <= 1'b0;
    else       rd_vld_q <= rd_gnt;
  end

  assign merged_masked = rd_vld_q ? merged : '0;

`ifdef DCACHE_DATA_BANK_OUTREG_EN
  logic          out_vld_q;
  logic [LW-1:0] out_dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= rd_vld_q;
      out_dat_q <= merged_masked;
    end
  end

  assign rd_valid_o = out_vld_q;
  assign rd_data_o  = out_dat_q;
`else
  assign rd_valid_o = rd_vld_q;
  assign rd_data_o  = merged_masked;
`endif

endmodule
